input_demultiplexer: RTL and testbench



---
 rtl/wavelet_pkg.sv | 20 ++
 rtl/byte_word_assembler.sv | 55 +++++
 rtl/input_demultiplexer.sv | 149 ++++++++++++++
 tb/tb_input_demultiplexer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wavelet_pkg.sv
// Shared definitions for the wavelet channel bus: FSM state codes, frame
// field positions and word-size helper used by both ends of the bus.
package wavelet_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t DATA   = 2'd1;
    localparam state_t COMMIT = 2'd2;

    // Header bytes carry a 1 in this bit; the remaining bits are the channel index.
    localparam int HEADER_FLAG_BIT     = 7;
    localparam int CHANNEL_INDEX_WIDTH = 7;

    // Number of stream bytes needed to carry one channel word.
    function automatic int bytes_per_word(input int word_width);
        return word_width / 8;
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Collects stream bytes LSB-first into a word. The counter points at the
// byte lane the next accepted byte lands in; done flags the final byte.
module byte_word_assembler
    import wavelet_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [7:0]            data,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  done
);

    localparam int BPW   = bytes_per_word(WORD_WIDTH);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic             last_byte;

    assign last_byte = (cnt_reg == CNT_W'(BPW - 1));
    assign done      = load && last_byte;

    // Byte counter: restarts on each header, wraps after the last byte of a word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= last_byte ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    // One register per byte lane, loaded when the counter selects that lane.
    generate
        for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
            logic [7:0] lane_reg;

            // Capture the accepted byte into this lane.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= '0;
                end else if (load && (cnt_reg == CNT_W'(gi))) begin
                    lane_reg <= data;
                end
            end

            assign word[gi*8 +: 8] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/input_demultiplexer.sv
// Receive side of the wavelet channel bus. Decodes header/data byte frames
// and writes each assembled word into the addressed channel register,
// pulsing that channel's strobe for one cycle. Bad indices and stray data
// bytes raise a sticky error flag.
module input_demultiplexer
    import wavelet_pkg::*;
#(
    parameter int NUM_FILTERS    = 8,
    parameter int SUM_TRUNCATION = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [7:0]                          i_data,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic                                i_clear_error,
    output logic [NUM_FILTERS*SUM_TRUNCATION-1:0] o_demux_out,
    output logic [NUM_FILTERS-1:0]              o_channel_strobe,
    output logic                                o_error
);

    state_t                         state_reg;
    state_t                         state_next;
    logic [CHANNEL_INDEX_WIDTH-1:0] index_reg;
    logic                           error_reg;
    logic                           error_next;

    logic                           accept;
    logic                           is_header;
    logic                           header_accept;
    logic                           data_accept;
    logic                           stray_error;
    logic                           index_valid;
    logic                           commit_write;
    logic                           commit_error;
    logic                           word_done;
    logic [SUM_TRUNCATION-1:0]      word;

    assign accept        = i_valid && o_ready;
    assign is_header     = i_data[HEADER_FLAG_BIT];
    assign header_accept = accept && (state_reg == IDLE) && is_header;
    assign stray_error   = accept && (state_reg == IDLE) && !is_header;
    assign data_accept   = accept && (state_reg == DATA);
    assign index_valid   = (int'(index_reg) < NUM_FILTERS);

    byte_word_assembler #(
        .WORD_WIDTH (SUM_TRUNCATION)
    ) u_assembler (
        .clk   (clk),
        .rst   (rst),
        .clear (header_accept),
        .load  (data_accept),
        .data  (i_data),
        .word  (word),
        .done  (word_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: header opens a frame, last data byte commits, commit always returns to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (header_accept) state_next = DATA;
            DATA:    if (word_done)     state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: stall the sender only for the single commit bubble.
    always_comb begin
        o_ready      = 1'b1;
        commit_write = 1'b0;
        commit_error = 1'b0;
        if (state_reg == COMMIT) begin
            o_ready      = 1'b0;
            commit_write = index_valid;
            commit_error = !index_valid;
        end
    end

    // Channel index latched from the header byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_reg <= '0;
        end else if (header_accept) begin
            index_reg <= i_data[CHANNEL_INDEX_WIDTH-1:0];
        end
    end

    // Sticky error: a new error wins over a simultaneous clear.
    always_comb begin
        error_next = error_reg;
        if (i_clear_error) error_next = 1'b0;
        if (stray_error || commit_error) error_next = 1'b1;
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_reg <= 1'b0;
        end else begin
            error_reg <= error_next;
        end
    end

    assign o_error = error_reg;

    // Per-channel word register and update strobe.
    generate
        for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : g_channel
            logic [SUM_TRUNCATION-1:0] slice_reg;
            logic                      strobe_reg;
            logic                      hit;

            assign hit = commit_write && (index_reg == CHANNEL_INDEX_WIDTH'(gi));

            // Channel register only changes when this channel is committed.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slice_reg <= '0;
                end else if (hit) begin
                    slice_reg <= word;
                end
            end

            // Strobe is high only in the cycle following this channel's commit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    strobe_reg <= 1'b0;
                end else begin
                    strobe_reg <= hit;
                end
            end

            assign o_demux_out[gi*SUM_TRUNCATION +: SUM_TRUNCATION] = slice_reg;
            assign o_channel_strobe[gi] = strobe_reg;
        end
    endgenerate

endmodule

// File: tb/tb_input_demultiplexer.sv
// Scoreboard bench for input_demultiplexer: a byte-level frame model pushes
// expected commits, a monitor pops them whenever a strobe appears.
module tb_input_demultiplexer;

    localparam int NF  = 8;
    localparam int W   = 8;
    localparam int BPW = W / 8;
    localparam int DW  = NF * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    i_data = '0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic          i_clear_error = 1'b0;
    logic [DW-1:0] o_demux_out;
    logic [NF-1:0] o_channel_strobe;
    logic          o_error;

    input_demultiplexer #(
        .NUM_FILTERS    (NF),
        .SUM_TRUNCATION (W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_data           (i_data),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_clear_error    (i_clear_error),
        .o_demux_out      (o_demux_out),
        .o_channel_strobe (o_channel_strobe),
        .o_error          (o_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NF-1:0] strobe;
        logic [DW-1:0] snap;
    } exp_t;

    exp_t sb[$];
    int   strobe_times[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   low_run  = 0;

    // Reference model state (frame-level view of the protocol)
    logic [W-1:0] mem [NF];
    bit           in_frame = 0;
    int           m_count  = 0;
    int           m_chan   = 0;
    logic [W-1:0] m_word   = '0;
    bit           exp_err  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] snapshot();
        logic [DW-1:0] s;
        for (int k = 0; k < NF; k++) s[k*W +: W] = mem[k];
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NF; k++) mem[k] = '0;
        in_frame = 0;
        m_count  = 0;
        m_word   = '0;
        exp_err  = 0;
    endtask

    // Apply one accepted byte to the model.
    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        if (!in_frame) begin
            if (b[7]) begin
                in_frame = 1;
                m_chan   = int'(b[6:0]);
                m_count  = 0;
            end else begin
                exp_err = 1;
            end
        end else begin
            m_word[m_count*8 +: 8] = b;
            m_count++;
            if (m_count == BPW) begin
                in_frame = 0;
                if (m_chan < NF) begin
                    mem[m_chan] = m_word;
                    e.strobe = '0;
                    e.strobe[m_chan] = 1'b1;
                    e.snap = snapshot();
                    sb.push_back(e);
                end else begin
                    exp_err = 1;
                end
            end
        end
    endtask

    // Drive one byte and wait (bounded) for it to be accepted.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        i_data  = b;
        i_valid = 1'b1;
        while (!o_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!o_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 for byte %0h", b);
        end else begin
            @(posedge clk);
            model_byte(b);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            i_valid = 1'b0;
        end
    endtask

    task automatic clear_error();
        @(negedge clk);
        i_valid       = 1'b0;
        i_clear_error = 1'b1;
        @(negedge clk);
        i_clear_error = 1'b0;
        exp_err = 0;
    endtask

    // Monitor: pop and compare on every strobe; flag any multi-cycle ready stall.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (o_channel_strobe != '0) begin
                    strobe_times.push_back(cyc);
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_strobe: got %0h expected none", o_channel_strobe);
                    end else begin
                        e = sb.pop_front();
                        check("strobe", DW'(o_channel_strobe), DW'(e.strobe));
                        check("demux_out", o_demux_out, e.snap);
                    end
                end
                if (!o_ready) begin
                    low_run++;
                    if (low_run > 1) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL ready_bubble: got ready low for %0d cycles expected 1", low_run);
                    end
                end else begin
                    low_run = 0;
                end
            end else begin
                low_run = 0;
            end
        end
    end

    initial begin
        int gap;
        int kind;
        int ch;
        int waited;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_demux", o_demux_out, '0);
        check("reset_strobe", DW'(o_channel_strobe), '0);
        check("reset_error", DW'(o_error), '0);
        check("reset_ready", DW'(o_ready), DW'(1));

        // Basic frame to channel 2, with single-cycle commit bubble
        send_byte(8'h82);
        send_byte(8'h5A);
        @(negedge clk);
        i_valid = 1'b0;
        check("commit_ready_low", DW'(o_ready), '0);
        @(negedge clk);
        check("after_commit_ready", DW'(o_ready), DW'(1));
        check("slice2", DW'(o_demux_out[2*W +: W]), DW'(8'h5A));
        idle(2);

        // Back-to-back frames with valid held high
        strobe_times.delete();
        send_byte(8'h80);
        send_byte(8'h11);
        send_byte(8'h87);
        send_byte(8'hEE);
        idle(3);
        check("b2b_strobe_count", DW'(strobe_times.size()), DW'(2));
        if (strobe_times.size() == 2)
            check("b2b_strobe_spacing", DW'(strobe_times[1] - strobe_times[0]), DW'(3));
        check("slice0", DW'(o_demux_out[0 +: W]), DW'(8'h11));
        check("slice7", DW'(o_demux_out[7*W +: W]), DW'(8'hEE));

        // Bad channel index
        send_byte(8'h8A);
        send_byte(8'h33);
        idle(3);
        check("bad_index_error", DW'(o_error), DW'(exp_err));
        check("bad_index_demux", o_demux_out, snapshot());
        clear_error();
        check("clear_error", DW'(o_error), DW'(exp_err));

        // Stray data byte in IDLE, then a valid frame
        send_byte(8'h25);
        idle(2);
        check("stray_error", DW'(o_error), DW'(exp_err));
        clear_error();
        send_byte(8'h81);
        send_byte(8'h44);
        idle(3);
        check("slice1", DW'(o_demux_out[1*W +: W]), DW'(8'h44));

        // Reset in the middle of a frame
        send_byte(8'h83);
        @(negedge clk);
        i_valid = 1'b0;
        rst     = 1'b1;
        model_reset();
        @(negedge clk);
        check("midrst_demux", o_demux_out, '0);
        check("midrst_strobe", DW'(o_channel_strobe), '0);
        check("midrst_error", DW'(o_error), '0);
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h83);
        send_byte(8'h99);
        idle(3);
        check("slice3_after_rst", o_demux_out, snapshot());

        // Gaps on i_valid between header and data
        strobe_times.delete();
        send_byte(8'h84);
        idle(3);
        check("gap_no_early_strobe", DW'(strobe_times.size()), '0);
        send_byte(8'h7F);
        idle(3);
        check("slice4", DW'(o_demux_out[4*W +: W]), DW'(8'h7F));

        // Randomized frames, stray bytes and gaps
        for (int it = 0; it < 120; it++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                send_byte(8'($urandom_range(0, 127)));
            end else begin
                ch = $urandom_range(0, 11);
                send_byte(8'h80 | 8'(ch));
                for (int b = 0; b < BPW; b++) begin
                    gap = $urandom_range(0, 3);
                    if (gap > 1) idle(gap - 1);
                    send_byte(8'($urandom_range(0, 255)));
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                idle(3);
                check("rand_error", DW'(o_error), DW'(exp_err));
                check("rand_demux", o_demux_out, snapshot());
                clear_error();
            end
        end

        // Drain and final state
        idle(3);
        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard_empty", DW'(sb.size()), '0);
        check("final_demux", o_demux_out, snapshot());
        check("final_error", DW'(o_error), DW'(exp_err));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
